imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
- Shares one single-ported memory between the processor's instruction port (imem) and data port (dmem).
- Sits between Proc and the memory model/SRAM. Serializes requests and allows one outstanding transaction.
- Routes each response back to the port that issued it. Back-pressures the losing port through a per-port rdy signal.

Parameters:
- DMEM_PRIORITY, 1, 1 = fixed priority to dmem on conflict; 0 = round-robin between imem and dmem.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- imemreq_val  input  1  instruction fetch request valid; held until accepted
- imemreq_rdy  output  1  fetch request accepted this cycle
- imemreq_addr  input  32  fetch address
- imemresp_val  output  1  fetch response valid (1-cycle pulse)
- imemresp_data  output  32  fetched instruction
- dmemreq_val  input  1  data request valid; held until accepted
- dmemreq_rdy  output  1  data request accepted this cycle
- dmemreq_type  input  1  0 = read, 1 = write
- dmemreq_addr  input  32  data address
- dmemreq_wdata  input  32  store data
- dmemresp_val  output  1  data response valid (1-cycle pulse; also for writes)
- dmemresp_rdata  output  32  load data; 0 for write responses
- memreq_val  output  1  memory request valid
- memreq_rdy  input  1  memory accepts request
- memreq_type  output  1  0 = read, 1 = write
- memreq_addr  output  32  memory address
- memreq_wdata  output  32  memory write data
- memresp_val  input  1  memory response valid
- memresp_rdata  input  32  memory read data

Behaviour:
- Reset (async, rst=1): state = IDLE, owner = dmem, last_grant = imem (so first round-robin conflict goes to dmem). All *_rdy, *_resp_val, and memreq_val are 0. Outputs are combinational from state, so they are 0 while rst=1.
- Handshake: a request is accepted when memreq_val && memreq_rdy. The winning port's rdy equals memreq_rdy in that cycle; the other port's rdy = 0.
- States:
  - IDLE: if any req_val, select winner, drive memreq_* from it, memreq_val = 1.
    - Accepted → BUSY, owner = winner, store owner type.
    - Not accepted → WAIT_RDY with the winner locked.
  - WAIT_RDY: drive memreq_* from the locked owner only. A new request from the other port cannot steal the grant. On accept → BUSY.
  - BUSY: memreq_val = 0, both rdy = 0. On memresp_val:
    - Pulse owner resp_val in the same cycle, with combinational pass-through of memresp_rdata. dmemresp_rdata = 0 if the stored type is write.
    - Go to IDLE. The next grant is issued earliest the following cycle.
- Arbitration on a conflict (both val in IDLE):
  - DMEM_PRIORITY=1: dmem wins.
  - DMEM_PRIORITY=0: the port not in last_grant wins.
  - last_grant updates on every accept.
- Non-owner resp_val and resp data are 0. Both resp data outputs are 0 whenever their resp_val = 0.
- Latency: accept in cycle N; response in the cycle the memory raises memresp_val (≥ N+1). With 1-cycle memory, throughput is 1 transaction per 2 cycles.
- Spurious memresp_val in IDLE or WAIT_RDY is ignored (no resp pulse).
- Reset mid-transaction: the outstanding response is dropped. The memory response arriving after rst deasserts is ignored as spurious.
- Address and data pass through unmodified (no alignment check).

Optional Feature:
- Macro: IMEM_DMEM_ARBITER_PERF_EN
- When defined, adds three 32-bit output ports and counters, reset to 0, wrapping at 2^32:
  - perf_imem_grants: increments on each imem accept.
  - perf_dmem_grants: increments on each dmem accept.
  - perf_conflicts: increments each IDLE cycle with both val = 1.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Single fetch, 1-cycle memory:
  - Stimulus: imemreq_val=1, addr=0x200; memory returns 0x00000013.
  - Response: imemreq_rdy=1 cycle 0; imemresp_val=1, data=0x00000013 cycle 1; dmemresp_val stays 0.
- Conflict, DMEM_PRIORITY=1:
  - Stimulus: imem addr 0x204 and dmem read 0x1000 both raised at cycle 0; mem[0x1000]=0xCAFE0001.
  - Response: dmem accepted cycle 0, dmemresp_rdata=0xCAFE0001 cycle 1; imem accepted cycle 2, response cycle 3.
- Round-robin, DMEM_PRIORITY=0:
  - Stimulus: both ports continuously valid for 8 cycles.
  - Response: grants alternate dmem, imem, dmem, imem; 4 responses total.
- Back-pressure lock:
  - Stimulus: memreq_rdy=0 for 3 cycles with imem valid; dmem raises val in cycle 1.
  - Response: memreq_addr stays at the imem address for all 3 cycles; imem is accepted when rdy rises; dmem is served next.
- Write response:
  - Stimulus: dmem write addr 0x2000, wdata 0x12345678.
  - Response: memreq_type=1, memreq_wdata=0x12345678; dmemresp_val=1 with rdata=0x00000000; a later read of 0x2000 returns 0x12345678.
- Reset mid-op:
  - Stimulus: rst asserted in BUSY, memory responds 1 cycle after deassert.
  - Response: no resp_val pulse; outputs 0 during reset; the next imem request is served normally. With PERF_EN, counters read 0 after reset.

Source files
------------

// File: rtl/imem_dmem_arbiter_if.sv
// Bus bundle between the processor ports, the arbiter and the shared memory.
// master: processor and memory side (drives requests and memory responses).
// slave:  arbiter side.
interface imem_dmem_arbiter_if;
  logic        imemreq_val;
  logic        imemreq_rdy;
  logic [31:0] imemreq_addr;
  logic        imemresp_val;
  logic [31:0] imemresp_data;

  logic        dmemreq_val;
  logic        dmemreq_rdy;
  logic        dmemreq_type;
  logic [31:0] dmemreq_addr;
  logic [31:0] dmemreq_wdata;
  logic        dmemresp_val;
  logic [31:0] dmemresp_rdata;

  logic        memreq_val;
  logic        memreq_rdy;
  logic        memreq_type;
  logic [31:0] memreq_addr;
  logic [31:0] memreq_wdata;
  logic        memresp_val;
  logic [31:0] memresp_rdata;

  modport master (
    output imemreq_val, imemreq_addr,
    input  imemreq_rdy, imemresp_val, imemresp_data,
    output dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_wdata,
    input  dmemreq_rdy, dmemresp_val, dmemresp_rdata,
    input  memreq_val, memreq_type, memreq_addr, memreq_wdata,
    output memreq_rdy, memresp_val, memresp_rdata
  );

  modport slave (
    input  imemreq_val, imemreq_addr,
    output imemreq_rdy, imemresp_val, imemresp_data,
    input  dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_wdata,
    output dmemreq_rdy, dmemresp_val, dmemresp_rdata,
    output memreq_val, memreq_type, memreq_addr, memreq_wdata,
    input  memreq_rdy, memresp_val, memresp_rdata
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-ported memory between the instruction and data ports.
// One outstanding transaction; responses are routed back to the issuing port.
// Optional performance counters are enabled by defining IMEM_DMEM_ARBITER_PERF_EN.
module imem_dmem_arbiter #(
  parameter logic DMEM_PRIORITY = 1'b1
) (
  input  logic clk,
  input  logic rst,
  imem_dmem_arbiter_if.slave bus
`ifdef IMEM_DMEM_ARBITER_PERF_EN
  ,
  output logic [31:0] perf_imem_grants,
  output logic [31:0] perf_dmem_grants,
  output logic [31:0] perf_conflicts
`endif
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_RDY = 2'd1;
  localparam logic [1:0] ST_BUSY     = 2'd2;

  localparam logic PORT_IMEM = 1'b0;
  localparam logic PORT_DMEM = 1'b1;

  logic [1:0] state_reg, state_next;
  logic       owner_reg, owner_next;
  logic       type_reg, type_next;
  logic       last_grant_reg, last_grant_next;

  logic any_val, both_val, idle_winner, grant, accept, resp_fire;

  assign any_val  = bus.imemreq_val | bus.dmemreq_val;
  assign both_val = bus.imemreq_val & bus.dmemreq_val;

  // Pick the winner among fresh requests in IDLE
  always_comb begin
    idle_winner = PORT_IMEM;
    if (both_val)
      idle_winner = DMEM_PRIORITY ? PORT_DMEM : ~last_grant_reg;
    else if (bus.dmemreq_val)
      idle_winner = PORT_DMEM;
  end

  // Once a request has been presented and stalled, the owner stays locked
  assign grant = (state_reg == ST_IDLE) ? idle_winner : owner_reg;

  // Drive the memory request from the granted port; silent while in reset
  always_comb begin
    bus.memreq_val = 1'b0;
    if (!rst) begin
      case (state_reg)
        ST_IDLE:     bus.memreq_val = any_val;
        ST_WAIT_RDY: bus.memreq_val = 1'b1;
        default:     bus.memreq_val = 1'b0;
      endcase
    end
    bus.memreq_type  = (grant == PORT_DMEM) ? bus.dmemreq_type  : 1'b0;
    bus.memreq_addr  = (grant == PORT_DMEM) ? bus.dmemreq_addr  : bus.imemreq_addr;
    bus.memreq_wdata = (grant == PORT_DMEM) ? bus.dmemreq_wdata : 32'h0;
  end

  assign accept          = bus.memreq_val & bus.memreq_rdy;
  assign bus.imemreq_rdy = accept & (grant == PORT_IMEM);
  assign bus.dmemreq_rdy = accept & (grant == PORT_DMEM);

  // Response routing: pass-through to the owner only, zero elsewhere
  assign resp_fire          = !rst && (state_reg == ST_BUSY) && bus.memresp_val;
  assign bus.imemresp_val   = resp_fire & (owner_reg == PORT_IMEM);
  assign bus.dmemresp_val   = resp_fire & (owner_reg == PORT_DMEM);
  assign bus.imemresp_data  = bus.imemresp_val ? bus.memresp_rdata : 32'h0;
  assign bus.dmemresp_rdata = (bus.dmemresp_val && !type_reg) ? bus.memresp_rdata : 32'h0;

  // Next-state and bookkeeping for owner, stored type and last grant
  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    type_next       = type_reg;
    last_grant_next = last_grant_reg;
    case (state_reg)
      ST_IDLE: begin
        if (any_val) begin
          owner_next = idle_winner;
          state_next = accept ? ST_BUSY : ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: begin
        if (accept) state_next = ST_BUSY;
      end
      ST_BUSY: begin
        if (bus.memresp_val) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (accept) begin
      type_next       = (grant == PORT_DMEM) & bus.dmemreq_type;
      last_grant_next = grant;
    end
  end

  // State registers; reset biases the first round-robin conflict toward dmem
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      owner_reg      <= PORT_DMEM;
      type_reg       <= 1'b0;
      last_grant_reg <= PORT_IMEM;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      type_reg       <= type_next;
      last_grant_reg <= last_grant_next;
    end
  end

`ifdef IMEM_DMEM_ARBITER_PERF_EN
  // Free-running event counters, wrap naturally at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_imem_grants <= 32'h0;
      perf_dmem_grants <= 32'h0;
      perf_conflicts   <= 32'h0;
    end else begin
      if (accept && grant == PORT_IMEM) perf_imem_grants <= perf_imem_grants + 32'd1;
      if (accept && grant == PORT_DMEM) perf_dmem_grants <= perf_dmem_grants + 32'd1;
      if (state_reg == ST_IDLE && both_val) perf_conflicts <= perf_conflicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for imem_dmem_arbiter: one priority instance and one round-robin
// instance, a transaction-level reference model and a memory model.
module tb_imem_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_dmem_arbiter_if bus_p ();
  imem_dmem_arbiter_if bus_r ();

`ifdef IMEM_DMEM_ARBITER_PERF_EN
  logic [31:0] pp_i, pp_d, pp_c, pr_i, pr_d, pr_c;
  imem_dmem_arbiter #(.DMEM_PRIORITY(1'b1)) dut_p (.clk(clk), .rst(rst), .bus(bus_p),
    .perf_imem_grants(pp_i), .perf_dmem_grants(pp_d), .perf_conflicts(pp_c));
  imem_dmem_arbiter #(.DMEM_PRIORITY(1'b0)) dut_r (.clk(clk), .rst(rst), .bus(bus_r),
    .perf_imem_grants(pr_i), .perf_dmem_grants(pr_d), .perf_conflicts(pr_c));
`else
  imem_dmem_arbiter #(.DMEM_PRIORITY(1'b1)) dut_p (.clk(clk), .rst(rst), .bus(bus_p));
  imem_dmem_arbiter #(.DMEM_PRIORITY(1'b0)) dut_r (.clk(clk), .rst(rst), .bus(bus_r));
`endif

  // Stimulus variables; sel picks the active instance (0 = priority, 1 = round-robin)
  logic        sel = 1'b0;
  logic        iv = 1'b0, dv = 1'b0, dt = 1'b0, mrdy = 1'b1, mrv = 1'b0;
  logic [31:0] ia = 32'h0, da = 32'h0, dw = 32'h0, mrd = 32'h0;

  assign bus_p.imemreq_val   = !sel & iv;
  assign bus_r.imemreq_val   =  sel & iv;
  assign bus_p.dmemreq_val   = !sel & dv;
  assign bus_r.dmemreq_val   =  sel & dv;
  assign bus_p.memreq_rdy    = !sel & mrdy;
  assign bus_r.memreq_rdy    =  sel & mrdy;
  assign bus_p.memresp_val   = !sel & mrv;
  assign bus_r.memresp_val   =  sel & mrv;
  assign bus_p.imemreq_addr  = ia;
  assign bus_r.imemreq_addr  = ia;
  assign bus_p.dmemreq_addr  = da;
  assign bus_r.dmemreq_addr  = da;
  assign bus_p.dmemreq_type  = dt;
  assign bus_r.dmemreq_type  = dt;
  assign bus_p.dmemreq_wdata = dw;
  assign bus_r.dmemreq_wdata = dw;
  assign bus_p.memresp_rdata = mrd;
  assign bus_r.memresp_rdata = mrd;

  // Observed outputs of the active instance
  logic        o_irdy, o_drdy, o_irv, o_drv, o_mval, o_mtype;
  logic [31:0] o_ird, o_drd, o_maddr, o_mwdata;
  assign o_irdy   = sel ? bus_r.imemreq_rdy    : bus_p.imemreq_rdy;
  assign o_drdy   = sel ? bus_r.dmemreq_rdy    : bus_p.dmemreq_rdy;
  assign o_irv    = sel ? bus_r.imemresp_val   : bus_p.imemresp_val;
  assign o_drv    = sel ? bus_r.dmemresp_val   : bus_p.dmemresp_val;
  assign o_ird    = sel ? bus_r.imemresp_data  : bus_p.imemresp_data;
  assign o_drd    = sel ? bus_r.dmemresp_rdata : bus_p.dmemresp_rdata;
  assign o_mval   = sel ? bus_r.memreq_val     : bus_p.memreq_val;
  assign o_mtype  = sel ? bus_r.memreq_type    : bus_p.memreq_type;
  assign o_maddr  = sel ? bus_r.memreq_addr    : bus_p.memreq_addr;
  assign o_mwdata = sel ? bus_r.memreq_wdata   : bus_p.memreq_wdata;

  // Sampled copies used by directed steps
  logic        s_irdy, s_drdy, s_irv, s_drv;
  logic [31:0] s_ird, s_drd, s_maddr;

  int n_total = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference model: one outstanding transaction, a stalled winner stays
  // locked, winner chosen from the arbitration rule per instance.
  logic [31:0] mem [logic [31:0]];
  bit          busy = 0, own_d = 0, own_w = 0, locked = 0, lock_d = 0;
  bit          last_d [2] = '{0, 0};
  logic [31:0] own_a = 0, own_rd = 0;
  int          lat = 1, lat_cnt = 0;
  bit          spur = 0, acc_i = 0, acc_d = 0;
  int unsigned pc_i [2] = '{0, 0};
  int unsigned pc_d [2] = '{0, 0};
  int unsigned pc_c [2] = '{0, 0};

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return ~a;
  endfunction

  // One clock cycle: sample and check, clock edge, update model, drive memory
  task automatic cycle();
    bit win_d, exp_mval, acc, fire;
    win_d = 0; exp_mval = 0; acc = 0; fire = 0;
    #1;
    s_irdy = o_irdy; s_drdy = o_drdy; s_irv = o_irv; s_drv = o_drv;
    s_ird = o_ird; s_drd = o_drd; s_maddr = o_maddr;
    acc_i = 0; acc_d = 0;
    if (rst) begin
      chk1("rst_memreq_val", o_mval, 1'b0);
      chk1("rst_imemreq_rdy", o_irdy, 1'b0);
      chk1("rst_dmemreq_rdy", o_drdy, 1'b0);
      chk1("rst_imemresp_val", o_irv, 1'b0);
      chk1("rst_dmemresp_val", o_drv, 1'b0);
    end else if (busy) begin
      fire = mrv;
      chk1("busy_memreq_val", o_mval, 1'b0);
      chk1("busy_imemreq_rdy", o_irdy, 1'b0);
      chk1("busy_dmemreq_rdy", o_drdy, 1'b0);
      chk1("imemresp_val", o_irv, fire && !own_d);
      chk("imemresp_data", o_ird, (fire && !own_d) ? mrd : 32'h0);
      chk1("dmemresp_val", o_drv, fire && own_d);
      chk("dmemresp_rdata", o_drd, (fire && own_d && !own_w) ? mrd : 32'h0);
    end else begin
      exp_mval = iv || dv;
      if (locked) win_d = lock_d;
      else if (iv && dv) win_d = (sel == 1'b0) ? 1'b1 : !last_d[sel];
      else win_d = dv;
      acc = exp_mval && mrdy;
      chk1("memreq_val", o_mval, exp_mval);
      if (exp_mval) begin
        chk("memreq_addr", o_maddr, win_d ? da : ia);
        chk1("memreq_type", o_mtype, win_d && dt);
        if (win_d && dt) chk("memreq_wdata", o_mwdata, dw);
      end
      chk1("imemreq_rdy", o_irdy, acc && !win_d);
      chk1("dmemreq_rdy", o_drdy, acc && win_d);
      chk1("idle_imemresp_val", o_irv, 1'b0);
      chk1("idle_dmemresp_val", o_drv, 1'b0);
      chk("idle_imemresp_data", o_ird, 32'h0);
      chk("idle_dmemresp_rdata", o_drd, 32'h0);
    end
`ifdef IMEM_DMEM_ARBITER_PERF_EN
    if (!rst) begin
      chk("perf_imem_grants", sel ? pr_i : pp_i, pc_i[sel]);
      chk("perf_dmem_grants", sel ? pr_d : pp_d, pc_d[sel]);
      chk("perf_conflicts",   sel ? pr_c : pp_c, pc_c[sel]);
    end
`endif
    @(posedge clk);
    if (rst) begin
      busy = 0; locked = 0; last_d[0] = 0; last_d[1] = 0;
      for (int k = 0; k < 2; k++) begin pc_i[k] = 0; pc_d[k] = 0; pc_c[k] = 0; end
    end else if (busy) begin
      if (fire) begin
        busy = 0;
        $display("txn dut=%0d port=%s type=%0d addr=%h data=%h", sel, own_d ? "dmem" : "imem",
                 own_w, own_a, (own_d && own_w) ? 32'h0 : mrd);
      end
    end else begin
      if (!locked && iv && dv) pc_c[sel]++;
      if (acc) begin
        busy = 1; own_d = win_d; own_w = win_d && dt; own_a = win_d ? da : ia;
        last_d[sel] = win_d; locked = 0; lat_cnt = lat;
        if (own_w) mem[da] = dw;
        own_rd = mem_rd(own_a);
        if (win_d) begin acc_d = 1; pc_d[sel]++; end
        else begin acc_i = 1; pc_i[sel]++; end
      end else if (exp_mval) begin
        locked = 1; lock_d = win_d;
      end
    end
    @(negedge clk);
    mrv = 1'b0; mrd = 32'h0;
    if (busy && !rst) begin
      lat_cnt--;
      if (lat_cnt <= 0) begin
        mrv = 1'b1;
        mrd = own_w ? ($urandom | 32'h1) : own_rd;
      end
    end else if (spur && !rst && $urandom_range(0, 7) == 0) begin
      mrv = 1'b1;
      mrd = $urandom;
    end
  endtask

  initial begin
    bit   i_pend, d_pend;
    bit   g_q [$];
    int   n_resp;

    // Reset state
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    cycle();

    // Single fetch with 1-cycle memory
    mem[32'h200] = 32'h00000013;
    iv = 1; ia = 32'h200;
    cycle();
    chk1("fetch_accept", s_irdy, 1'b1);
    iv = 0;
    cycle();
    chk1("fetch_resp_val", s_irv, 1'b1);
    chk("fetch_resp_data", s_ird, 32'h00000013);
    chk1("fetch_no_dresp", s_drv, 1'b0);

    // Conflict with fixed dmem priority
    mem[32'h1000] = 32'hCAFE0001;
    mem[32'h204]  = 32'h00100093;
    iv = 1; ia = 32'h204; dv = 1; dt = 0; da = 32'h1000;
    cycle();
    chk1("prio_dmem_first", s_drdy, 1'b1);
    chk1("prio_imem_waits", s_irdy, 1'b0);
    dv = 0;
    cycle();
    chk("prio_dmem_data", s_drd, 32'hCAFE0001);
    cycle();
    chk1("prio_imem_second", s_irdy, 1'b1);
    iv = 0;
    cycle();
    chk("prio_imem_data", s_ird, 32'h00100093);

    // Back-pressure keeps the stalled imem request locked
    mrdy = 0; iv = 1; ia = 32'h300;
    cycle();
    chk("bp_addr0", s_maddr, 32'h300);
    dv = 1; dt = 0; da = 32'h1004;
    cycle();
    chk("bp_addr1", s_maddr, 32'h300);
    chk1("bp_no_steal", s_drdy, 1'b0);
    cycle();
    chk("bp_addr2", s_maddr, 32'h300);
    mrdy = 1;
    cycle();
    chk1("bp_imem_accept", s_irdy, 1'b1);
    iv = 0;
    cycle();
    chk1("bp_imem_resp", s_irv, 1'b1);
    cycle();
    chk1("bp_dmem_next", s_drdy, 1'b1);
    dv = 0;
    cycle();
    chk1("bp_dmem_resp", s_drv, 1'b1);

    // Write response, then read back
    dv = 1; dt = 1; da = 32'h2000; dw = 32'h12345678;
    cycle();
    chk1("wr_accept", s_drdy, 1'b1);
    dv = 0;
    cycle();
    chk1("wr_resp_val", s_drv, 1'b1);
    chk("wr_resp_zero", s_drd, 32'h0);
    dv = 1; dt = 0; da = 32'h2000;
    cycle();
    dv = 0;
    cycle();
    chk("rd_after_wr", s_drd, 32'h12345678);

    // Round-robin instance, both ports continuously valid
    sel = 1; iv = 1; ia = 32'h400; dv = 1; dt = 0; da = 32'h1100;
    g_q.delete(); n_resp = 0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (s_irdy) g_q.push_back(1'b0);
      if (s_drdy) g_q.push_back(1'b1);
      if (s_irv || s_drv) n_resp++;
    end
    iv = 0; dv = 0;
    chk("rr_grants", g_q.size(), 4);
    for (int k = 0; k < g_q.size() && k < 4; k++) chk1("rr_order", g_q[k], (k % 2) == 0);
    chk("rr_resps", n_resp, 4);
    cycle();
    sel = 0;

    // Reset while a transaction is outstanding
    lat = 3; iv = 1; ia = 32'h208;
    cycle();
    iv = 0;
    cycle();
    rst = 1; iv = 1; ia = 32'h20C; lat = 1;
    cycle();
    rst = 0; mrv = 1; mrd = 32'hDEAD0000;
    cycle();
    chk1("rst_drop_resp", s_irv, 1'b0);
    chk1("rst_new_accept", s_irdy, 1'b1);
    iv = 0;
    cycle();
    chk1("rst_next_resp", s_irv, 1'b1);
    chk("rst_next_data", s_ird, ~32'h20C);

    // Randomized traffic on both instances
    for (int seg = 0; seg < 2; seg++) begin
      sel = seg[0]; spur = 1; i_pend = 0; d_pend = 0;
      for (int c = 0; c < 300; c++) begin
        mrdy = ($urandom_range(0, 3) != 0);
        lat  = $urandom_range(1, 3);
        if (!i_pend && $urandom_range(0, 1) == 1) begin
          i_pend = 1; ia = {$urandom_range(0, 255), 2'b00};
        end
        if (!d_pend && $urandom_range(0, 1) == 1) begin
          d_pend = 1; dt = $urandom_range(0, 1) == 1; dw = $urandom;
          da = 32'h3000 + {$urandom_range(0, 15), 2'b00};
        end
        iv = i_pend; dv = d_pend;
        cycle();
        if (acc_i) i_pend = 0;
        if (acc_d) d_pend = 0;
        iv = i_pend; dv = d_pend;
      end
      spur = 0; mrdy = 1;
      for (int c = 0; c < 50 && (busy || i_pend || d_pend); c++) begin
        iv = i_pend; dv = d_pend;
        cycle();
        if (acc_i) i_pend = 0;
        if (acc_d) d_pend = 0;
      end
      iv = 0; dv = 0;
      chk1("drain_done", busy || i_pend || d_pend, 1'b0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
